// File: rtl/top2_scanner.sv
// ---------------------------------------------------------------------------
// top2_scanner
// Walks every word of an external synchronous-read RAM once. It reports the
// largest value, the lowest address holding it, and the largest value that is
// strictly smaller than it.
//
// Ports
//   clk          : rising-edge clock
//   reset        : synchronous, active-high reset
//   start        : scan request, only looked at while idle
//   raddr        : registered RAM read address
//   rdata        : RAM read data, valid one cycle after raddr
//   busy         : high while addresses are issued and the last word drains
//   done         : one-cycle pulse once the final results are in place
//   max_val      : highest value seen
//   max_idx      : lowest address holding max_val
//   second_val   : highest value strictly below max_val
//   second_valid : at least two distinct values have been seen
// ---------------------------------------------------------------------------
module top2_scanner #(
   parameter int SIZE  = 32,
   parameter int ADDRW = $clog2(SIZE),
   parameter int DATAW = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic [ADDRW-1:0] raddr,
   input  logic [DATAW-1:0] rdata,
   output logic             busy,
   output logic             done,
   output logic [DATAW-1:0] max_val,
   output logic [ADDRW-1:0] max_idx,
   output logic [DATAW-1:0] second_val,
   output logic             second_valid
);

   localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(SIZE - 1);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DRAIN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [ADDRW-1:0] raddr_q, raddr_d;
   logic             sampleValid_q, sampleValid_d;
   logic [ADDRW-1:0] sampleIdx_q, sampleIdx_d;
   logic             seen_q, seen_d;
   logic [DATAW-1:0] maxVal_q, maxVal_d;
   logic [ADDRW-1:0] maxIdx_q, maxIdx_d;
   logic [DATAW-1:0] secondVal_q, secondVal_d;
   logic             secondValid_q, secondValid_d;

   // Every piece of state lives here. Reset wins over everything, so an
   // undefined rdata during reset can never leak into the results.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         raddr_q       <= '0;
         sampleValid_q <= 1'b0;
         sampleIdx_q   <= '0;
         seen_q        <= 1'b0;
         maxVal_q      <= '0;
         maxIdx_q      <= '0;
         secondVal_q   <= '0;
         secondValid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         raddr_q       <= raddr_d;
         sampleValid_q <= sampleValid_d;
         sampleIdx_q   <= sampleIdx_d;
         seen_q        <= seen_d;
         maxVal_q      <= maxVal_d;
         maxIdx_q      <= maxIdx_d;
         secondVal_q   <= secondVal_d;
         secondValid_q <= secondValid_d;
      end
   end

   // Next-state logic, address generation and result tracking.
   // An address issued in SCAN returns data one cycle later. The valid/index
   // pair therefore follows raddr by one cycle, and rdata is only looked at
   // when that pair marks a sample.
   always_comb begin
      state_d       = state_q;
      raddr_d       = raddr_q;
      seen_d        = seen_q;
      maxVal_d      = maxVal_q;
      maxIdx_d      = maxIdx_q;
      secondVal_d   = secondVal_q;
      secondValid_d = secondValid_q;
      sampleValid_d = (state_q == SCAN);
      sampleIdx_d   = raddr_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d       = SCAN;
               raddr_d       = '0;
               seen_d        = 1'b0;
               maxVal_d      = '0;
               maxIdx_d      = '0;
               secondVal_d   = '0;
               secondValid_d = 1'b0;
            end
         end
         SCAN: begin
            if (raddr_q == LAST_ADDR) begin
               state_d = DRAIN;
            end else begin
               raddr_d = raddr_q + 1'b1;
            end
         end
         DRAIN:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A sample equal to the current maximum changes nothing. This keeps the
      // lowest index, and a duplicate maximum never counts as a second value.
      if (sampleValid_q) begin
         if (!seen_q) begin
            seen_d   = 1'b1;
            maxVal_d = rdata;
            maxIdx_d = sampleIdx_q;
         end else if (rdata > maxVal_q) begin
            secondVal_d   = maxVal_q;
            secondValid_d = 1'b1;
            maxVal_d      = rdata;
            maxIdx_d      = sampleIdx_q;
         end else if ((rdata < maxVal_q) && (!secondValid_q || (rdata > secondVal_q))) begin
            secondVal_d   = rdata;
            secondValid_d = 1'b1;
         end
      end
   end

   assign raddr        = raddr_q;
   assign busy         = (state_q == SCAN) || (state_q == DRAIN);
   assign done         = (state_q == DONE);
   assign max_val      = maxVal_q;
   assign max_idx      = maxIdx_q;
   assign second_val   = secondVal_q;
   assign second_valid = secondValid_q;

endmodule

// File: tb/tb_top2_scanner.sv
// ---------------------------------------------------------------------------
// tb_top2_scanner
// Drives top2_scanner (SIZE=4, DATAW=8) against a one-cycle-latency RAM model.
// Directed and random contents are compared with a reference model that
// recomputes the top two values straight from the array contents.
// ---------------------------------------------------------------------------
module tb_top2_scanner;

   localparam int SIZE  = 4;
   localparam int ADDRW = 2;
   localparam int DATAW = 8;

   logic             clk;
   logic             reset;
   logic             start;
   logic [ADDRW-1:0] raddr;
   logic [DATAW-1:0] rdata;
   logic             busy;
   logic             done;
   logic [DATAW-1:0] max_val;
   logic [ADDRW-1:0] max_idx;
   logic [DATAW-1:0] second_val;
   logic             second_valid;

   logic [DATAW-1:0] mem [SIZE];
   logic [DATAW-1:0] ramQ;
   logic             rdataX;

   int checks;
   int failures;

   top2_scanner #(.SIZE(SIZE), .ADDRW(ADDRW), .DATAW(DATAW)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .raddr        (raddr),
      .rdata        (rdata),
      .busy         (busy),
      .done         (done),
      .max_val      (max_val),
      .max_idx      (max_idx),
      .second_val   (second_val),
      .second_valid (second_valid)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous-read RAM. rdataX lets the bench float the data bus to X.
   always @(posedge clk) ramQ <= mem[raddr];
   assign rdata = rdataX ? {DATAW{1'bx}} : ramQ;

   // Reference: the maximum, its first address, and the largest value below it.
   task automatic refModel(output logic [DATAW-1:0] eMax, output logic [ADDRW-1:0] eIdx,
                           output logic [DATAW-1:0] eSec, output logic eSv);
      int best;
      int idx;
      int sec;
      best = -1;
      idx  = 0;
      sec  = -1;
      for (int i = 0; i < SIZE; i++) begin
         if (int'(mem[i]) > best) begin
            best = int'(mem[i]);
            idx  = i;
         end
      end
      for (int i = 0; i < SIZE; i++) begin
         if (int'(mem[i]) < best && int'(mem[i]) > sec) sec = int'(mem[i]);
      end
      eMax = DATAW'(best);
      eIdx = ADDRW'(idx);
      eSv  = (sec >= 0);
      eSec = eSv ? DATAW'(sec) : '0;
   endtask

   // Must be called at a negedge while the DUT is idle; that cycle is cycle 0.
   // Walks cycles 1..SIZE+2 and notes the first cycle where raddr/busy/done
   // leave their expected timeline. Returns at the negedge of the done cycle.
   task automatic applyStimulus(input bit hold, output bit seqOk, output int badCycle);
      logic [ADDRW-1:0] expAddr;
      start    = 1'b1;
      seqOk    = 1'b1;
      badCycle = -1;
      for (int cyc = 1; cyc <= SIZE + 2; cyc++) begin
         @(negedge clk);
         if (!hold) start = 1'b0;
         expAddr = (cyc <= SIZE) ? ADDRW'(cyc - 1) : ADDRW'(SIZE - 1);
         if (seqOk && ((raddr !== expAddr) || (busy !== (cyc <= SIZE + 1)) ||
                       (done !== (cyc == SIZE + 2)))) begin
            seqOk    = 1'b0;
            badCycle = cyc;
         end
      end
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      start  = 1'b1;
      rdataX = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({raddr, busy, done, max_val, max_idx, second_val, second_valid} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_state: got raddr=%0d busy=%b done=%b max=%h idx=%0d sec=%h sv=%b, want all zero",
                  raddr, busy, done, max_val, max_idx, second_val, second_valid);
      end
      reset  = 1'b0;
      start  = 1'b0;
      rdataX = 1'b0;
      @(negedge clk);
   endtask

   // Directed contents. Each word lists mem[0]..mem[3] from the top byte down.
   task automatic test_directed();
      logic [31:0]      vecs [4];
      logic [31:0]      v;
      logic [DATAW-1:0] eMax, eSec;
      logic [ADDRW-1:0] eIdx;
      logic             eSv;
      bit               seqOk;
      int               badCycle;
      vecs[0] = 32'h03090507;
      vecs[1] = 32'h05050505;
      vecs[2] = 32'hFFFF00FE;
      vecs[3] = 32'h01020304;
      for (int n = 0; n < 4; n++) begin
         v = vecs[n];
         for (int i = 0; i < SIZE; i++) mem[i] = v[31 - 8 * i -: 8];
         refModel(eMax, eIdx, eSec, eSv);
         applyStimulus(1'b0, seqOk, badCycle);
         checks++;
         if (seqOk !== 1'b1) begin
            failures++;
            $display("[TB] FAIL directed%0d_timeline: got deviation at cycle %0d, want none", n, badCycle);
         end
         checks++;
         if ({max_val, max_idx, second_valid} !== {eMax, eIdx, eSv} ||
             (eSv && second_val !== eSec)) begin
            failures++;
            $display("[TB] FAIL directed%0d_result: got max=%h idx=%0d sec=%h sv=%b, want max=%h idx=%0d sec=%h sv=%b",
                     n, max_val, max_idx, second_val, second_valid, eMax, eIdx, eSec, eSv);
         end
         // Results must persist through idle cycles.
         repeat (3) @(negedge clk);
         checks++;
         if ({max_val, max_idx, second_valid, done, busy} !== {eMax, eIdx, eSv, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL directed%0d_hold: got max=%h idx=%0d sv=%b done=%b busy=%b, want max=%h idx=%0d sv=%b done=0 busy=0",
                     n, max_val, max_idx, second_valid, done, busy, eMax, eIdx, eSv);
         end
      end
   endtask

   task automatic test_random();
      logic [DATAW-1:0] eMax, eSec;
      logic [ADDRW-1:0] eIdx;
      logic             eSv;
      bit               seqOk;
      int               badCycle;
      for (int n = 0; n < 24; n++) begin
         for (int i = 0; i < SIZE; i++) begin
            mem[i] = (n % 2 == 0) ? DATAW'($urandom_range(0, 3)) : DATAW'($urandom_range(0, 255));
         end
         refModel(eMax, eIdx, eSec, eSv);
         applyStimulus(1'b0, seqOk, badCycle);
         checks++;
         if (!seqOk || {max_val, max_idx, second_valid} !== {eMax, eIdx, eSv} ||
             (eSv && second_val !== eSec)) begin
            failures++;
            $display("[TB] FAIL random%0d: got max=%h idx=%0d sec=%h sv=%b badCycle=%0d, want max=%h idx=%0d sec=%h sv=%b badCycle=-1",
                     n, max_val, max_idx, second_val, second_valid, badCycle, eMax, eIdx, eSec, eSv);
         end
         @(negedge clk);
      end
   endtask

   // Reset lands in cycle 3 of a scan; no done may appear, and a start on the
   // very next cycle must run a clean scan.
   task automatic test_reset_abort();
      logic [DATAW-1:0] eMax, eSec;
      logic [ADDRW-1:0] eIdx;
      logic             eSv;
      bit               seqOk;
      int               badCycle;
      bit               sawDone;
      mem[0] = 8'h10; mem[1] = 8'h80; mem[2] = 8'h40; mem[3] = 8'h20;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      sawDone = 1'b0;
      repeat (2) begin
         @(negedge clk);
         sawDone |= (done === 1'b1);
      end
      reset  = 1'b1;
      rdataX = 1'b1;
      repeat (3) begin
         @(negedge clk);
         sawDone |= (done === 1'b1);
      end
      checks++;
      if (sawDone || {raddr, busy, done, max_val, max_idx, second_val, second_valid} !== '0) begin
         failures++;
         $display("[TB] FAIL abort_state: got sawDone=%b raddr=%0d busy=%b max=%h idx=%0d sec=%h sv=%b, want all zero",
                  sawDone, raddr, busy, max_val, max_idx, second_val, second_valid);
      end
      reset  = 1'b0;
      rdataX = 1'b0;
      mem[0] = 8'h22; mem[1] = 8'h11; mem[2] = 8'h33; mem[3] = 8'h33;
      refModel(eMax, eIdx, eSec, eSv);
      applyStimulus(1'b0, seqOk, badCycle);
      checks++;
      if (!seqOk || {max_val, max_idx, second_val, second_valid} !== {eMax, eIdx, eSec, eSv}) begin
         failures++;
         $display("[TB] FAIL abort_restart: got max=%h idx=%0d sec=%h sv=%b badCycle=%0d, want max=%h idx=%0d sec=%h sv=%b badCycle=-1",
                  max_val, max_idx, second_val, second_valid, badCycle, eMax, eIdx, eSec, eSv);
      end
      @(negedge clk);
   endtask

   // start held high: each scan is followed by exactly one idle cycle.
   task automatic test_back_to_back();
      logic [DATAW-1:0] eMax, eSec;
      logic [ADDRW-1:0] eIdx;
      logic             eSv;
      bit               seqOk;
      int               badCycle;
      mem[0] = 8'h07; mem[1] = 8'hC0; mem[2] = 8'hC0; mem[3] = 8'hBF;
      refModel(eMax, eIdx, eSec, eSv);
      for (int n = 0; n < 3; n++) begin
         applyStimulus(1'b1, seqOk, badCycle);
         checks++;
         if (!seqOk || {max_val, max_idx, second_val, second_valid} !== {eMax, eIdx, eSec, eSv}) begin
            failures++;
            $display("[TB] FAIL b2b%0d_scan: got max=%h idx=%0d sec=%h sv=%b badCycle=%0d, want max=%h idx=%0d sec=%h sv=%b badCycle=-1",
                     n, max_val, max_idx, second_val, second_valid, badCycle, eMax, eIdx, eSec, eSv);
         end
         @(negedge clk);
         checks++;
         if ({busy, done} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL b2b%0d_idle_gap: got busy=%b done=%b, want busy=0 done=0", n, busy, done);
         end
      end
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL b2b_stop: got busy=%b, want 0", busy);
      end
   endtask

   task automatic checkOutput();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      start    = 1'b0;
      rdataX   = 1'b1;
      for (int i = 0; i < SIZE; i++) mem[i] = '0;
      @(negedge clk);
      test_reset();
      test_directed();
      test_random();
      test_reset_abort();
      test_back_to_back();
      checkOutput();
      $finish;
   end

endmodule

// File: doc/top2_scanner.md
TOP2_SCANNER -- requirements
Module: top2_scanner

Interface
REQ-001 SHALL have parameter SIZE, default 32, number of words in the scanned RAM (SIZE >= 2).
REQ-002 SHALL have parameter ADDRW, default $clog2(SIZE), RAM address width.
REQ-003 SHALL have parameter DATAW, default 8, RAM data width.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  scan request, sampled only in IDLE.
REQ-007 SHALL have port raddr  output  ADDRW  read address to RAM, registered.
REQ-008 SHALL have port rdata  input  DATAW  RAM read data, valid one cycle after raddr.
REQ-009 SHALL have port busy  output  1  scan in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at scan completion.
REQ-011 SHALL have port max_val  output  DATAW  highest value found.
REQ-012 SHALL have port max_idx  output  ADDRW  lowest address holding max_val.
REQ-013 SHALL have port second_val  output  DATAW  highest value strictly below max_val.
REQ-014 SHALL have port second_valid  output  1  second_val meaningful (at least two distinct values seen).

Function
REQ-015 SHALL implement FSM states IDLE, SCAN, DRAIN, DONE; IDLE->SCAN on start; SCAN->DRAIN after issuing address SIZE-1; DRAIN->DONE after last data is consumed; DONE->IDLE unconditionally.
REQ-016 SHALL, when start is high in IDLE (cycle 0), clear max_val, max_idx, second_val, second_valid and the internal first-sample flag, and drive raddr = 0 in cycle 1.
REQ-017 SHALL drive raddr = k in cycle k+1 for k = 0..SIZE-1, incrementing by 1 per cycle with no stalls.
REQ-018 SHALL consume rdata as mem[k] in cycle k+2, tracked by a one-cycle-delayed valid/index pipeline, and never sample rdata in other cycles.
REQ-019 SHALL treat all data as unsigned, DATAW bits, with no width extension of stored values.
REQ-020 SHALL, for the first consumed sample d at index k, set max_val = d and max_idx = k.
REQ-021 SHALL, for a later sample d > max_val, move max_val to second_val, set second_valid = 1, and set max_val = d, max_idx = k.
REQ-022 SHALL, for d == max_val, leave all results unchanged (keeps lowest index, duplicates of max are not second).
REQ-023 SHALL, for d < max_val with second_valid = 0 or d > second_val, set second_val = d and second_valid = 1.
REQ-024 SHALL assert busy in cycles 1..SIZE+1 (SCAN and DRAIN), deasserted otherwise.
REQ-025 SHALL assert done for exactly cycle SIZE+2 (DONE state), with final results stable from that cycle.
REQ-026 SHALL hold raddr at its last value outside SCAN.
REQ-027 SHALL hold results until the next accepted start.
REQ-028 SHALL ignore start in SCAN, DRAIN and DONE; a start held high through DONE is accepted in the following IDLE cycle.

Reset
REQ-029 SHALL, while reset is high, force state IDLE, raddr = 0, busy = 0, done = 0, max_val = 0, max_idx = 0, second_val = 0, second_valid = 0, regardless of start or rdata, including X on rdata.
REQ-030 SHALL abort a scan on reset mid-operation with no done pulse and results cleared, accepting a new start on the first cycle after reset deasserts.

Verification
REQ-031 SHALL pass: SIZE=4, mem={03,09,05,07}, start pulse -> raddr 0,1,2,3 in cycles 1-4, done in cycle 6, max_val=09, max_idx=1, second_val=07, second_valid=1.
REQ-032 SHALL pass: mem={05,05,05,05} -> max_val=05, max_idx=0, second_valid=0.
REQ-033 SHALL pass: mem={FF,FF,00,FE} -> max_val=FF, max_idx=0, second_val=FE, second_valid=1.
REQ-034 SHALL pass: mem ascending {01,02,03,04} -> max_val=04, max_idx=3, second_val=03, second_valid=1.
REQ-035 SHALL pass: reset asserted in cycle 3 of a scan -> no done pulse, all outputs 0; a new start afterwards gives the correct results.
REQ-036 SHALL pass: start held high continuously -> back-to-back scans with one IDLE cycle between each DONE and the next SCAN, and identical results on each scan.
